// File: rtl/vending_controller.sv
// Coin-operated vending controller: credits 5/10 coins, vends one-hot selected items
// against a per-item stock count, and pays change back as a stream of 5-value coins.
module vending_controller #(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {6'd9, 6'd7, 6'd5, 6'd3},
  parameter int                            STOCK_W    = 4,
  parameter int                            STOCK_INIT = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 five_in,
  input  logic                 ten_in,
  input  logic [NUM_ITEMS-1:0] item_sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 dispense,
  output logic [NUM_ITEMS-1:0] dispensed_item,
  output logic                 five_out,
  output logic                 coin_reject,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic [CREDIT_W-1:0]  credit
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_e;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [IDX_W-1:0] idx);
    price_of = PRICE_LIST[int'(idx)*CREDIT_W +: CREDIT_W];
  endfunction

  function automatic logic is_onehot(input logic [NUM_ITEMS-1:0] v);
    is_onehot = (v != '0) && ((v & (v - NUM_ITEMS'(1))) == '0);
  endfunction

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic                 reject_d;

  logic                 dispense_q;
  logic [NUM_ITEMS-1:0] dispensed_q;
  logic                 five_q;
  logic                 reject_q;
  logic                 busy_q;
  logic [NUM_ITEMS-1:0] sold_out_q;

  logic                 coin_any_s;
  logic [CREDIT_W:0]    coin_sum_s;
  logic                 sat_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 sel_ok_s;

  // The coin code {ten,five} is already the credit increment: 1, 2 or 3.
  assign coin_any_s = five_in | ten_in;
  assign coin_sum_s = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, ten_in, five_in};
  assign sat_s      = coin_sum_s[CREDIT_W];

  // Encode the requested item index (meaningful only when item_sel is one-hot).
  always_comb begin
    sel_idx_s = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  assign sel_ok_s = is_onehot(item_sel)
                 && (credit_q >= price_of(sel_idx_s))
                 && (stock_q[sel_idx_s] != '0);

  // Next-state, credit and stock update.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_any_s) begin
          if (sat_s) begin
            reject_d = 1'b1;
          end else begin
            credit_d = coin_sum_s[CREDIT_W-1:0];
            state_d  = (coin_sum_s != '0) ? S_ACCUM : S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
        if (restock) begin
          for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = STOCK_W'(STOCK_INIT);
          end
        end else begin
          stock_d = stock_q;
        end
      end
      S_ACCUM: begin
        // A coin in the same cycle masks both cancel and selection.
        if (coin_any_s) begin
          if (sat_s) begin
            reject_d = 1'b1;
          end else begin
            credit_d = coin_sum_s[CREDIT_W-1:0];
          end
        end else if (cancel) begin
          state_d = S_CHANGE;
        end else if (sel_ok_s) begin
          credit_d           = credit_q - price_of(sel_idx_s);
          stock_d[sel_idx_s] = stock_q[sel_idx_s] - STOCK_W'(1);
          state_d            = S_VEND;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_VEND: begin
        reject_d = coin_any_s;
        state_d  = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        reject_d = coin_any_s;
        credit_d = credit_q - CREDIT_W'(1);
        state_d  = (credit_q == CREDIT_W'(1)) ? S_IDLE : S_CHANGE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // State, stock and registered Moore outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
      dispense_q  <= 1'b0;
      dispensed_q <= '0;
      five_q      <= 1'b0;
      reject_q    <= 1'b0;
      busy_q      <= 1'b0;
      sold_out_q  <= {NUM_ITEMS{(STOCK_INIT == 0)}};
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      stock_q     <= stock_d;
      dispense_q  <= (state_d == S_VEND);
      dispensed_q <= (state_d == S_VEND) ? item_sel : '0;
      five_q      <= (state_d == S_CHANGE);
      reject_q    <= reject_d;
      busy_q      <= (state_d == S_VEND) || (state_d == S_CHANGE);
      for (int i = 0; i < NUM_ITEMS; i++) begin
        sold_out_q[i] <= (stock_d[i] == '0);
      end
    end
  end

  assign dispense       = dispense_q;
  assign dispensed_item = dispensed_q;
  assign five_out       = five_q;
  assign coin_reject    = reject_q;
  assign busy           = busy_q;
  assign sold_out       = sold_out_q;
  assign credit         = credit_q;

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter NUM_ITEMS, default 4: number of selectable items.
REQ-002 Parameter CREDIT_W, default 6: credit register width, in units of 5.
REQ-003 Parameter PRICE_LIST, default {9,7,5,3}: packed NUM_ITEMS x CREDIT_W vector of item prices in units of 5, item 0 in the LSBs; every entry >= 1.
REQ-004 Parameter STOCK_W, default 4: per-item stock counter width.
REQ-005 Parameter STOCK_INIT, default 10: stock loaded at reset and on restock.
REQ-006 clock  input  1  clock; all state changes on the rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 five_in  input  1  5-value coin inserted this cycle (one-cycle pulse).
REQ-009 ten_in  input  1  10-value coin inserted this cycle (one-cycle pulse).
REQ-010 item_sel  input  NUM_ITEMS  one-hot item selection request.
REQ-011 cancel  input  1  refund request.
REQ-012 restock  input  1  reload all stock counters.
REQ-013 dispense  output  1  one-cycle vend pulse.
REQ-014 dispensed_item  output  NUM_ITEMS  one-hot vended item; valid only while dispense=1, otherwise 0.
REQ-015 five_out  output  1  one 5-value change coin per high cycle.
REQ-016 coin_reject  output  1  one-cycle pulse: a coin was not credited.
REQ-017 busy  output  1  high in VEND and CHANGE.
REQ-018 sold_out  output  NUM_ITEMS  bit i high when stock[i]==0.
REQ-019 credit  output  CREDIT_W  current credit register, in units of 5.

Function
REQ-020 FSM states: IDLE (credit==0), ACCUM, VEND, CHANGE. Outputs are Moore/registered: dispense=1 only in VEND; five_out=1 only in CHANGE.
REQ-021 IDLE/ACCUM coin: credit += five_in*1 + ten_in*2 (both high adds 3); result > 0 moves the FSM to ACCUM.
REQ-022 Saturation: if the sum exceeds 2^CREDIT_W-1, the whole cycle's coins are rejected, credit is unchanged, and coin_reject pulses the next cycle.
REQ-023 In ACCUM, coin precedes selection: a cycle with any coin ignores item_sel and cancel.
REQ-024 Cancel in ACCUM with no coin: go to CHANGE; cancel takes priority over item_sel in the same cycle.
REQ-025 Valid selection, all required: item_sel one-hot, credit >= price[i], stock[i] > 0. Action: credit -= price[i], stock[i] -= 1, go to VEND.
REQ-026 Invalid selection (zero, multi-hot, underfunded or sold out): ignored; state and credit unchanged.
REQ-027 VEND lasts exactly one cycle with dispensed_item = the latched selection. Next state is CHANGE if credit > 0, else IDLE.
REQ-028 CHANGE: each cycle five_out=1 and credit decrements by 1; the FSM leaves for IDLE on the edge where credit reaches 0. Pulse count equals the credit on entry.
REQ-029 Coins in VEND/CHANGE are rejected with coin_reject; item_sel and cancel are ignored.
REQ-030 Restock is honoured only in IDLE (all stock := STOCK_INIT); otherwise it is ignored.
REQ-031 item_sel in IDLE is ignored, since every price is >= 1.

Reset
REQ-032 On reset: state=IDLE, credit=0, all stock=STOCK_INIT, and every output=0 except sold_out (0 when STOCK_INIT>0).
REQ-033 Reset has priority in every state; reset during CHANGE discards the remaining refund, and five_out=0 from the next cycle.

Verification
REQ-034 Ten, ten, item_sel=0001 (price 3) -> dispense=1 for 1 cycle with dispensed_item=0001, then exactly 1 five_out pulse, then IDLE with credit=0.
REQ-035 Five, five, cancel -> exactly 2 five_out pulses, dispense never high, then IDLE.
REQ-036 Five, then item_sel=1000 (price 9) -> no dispense, credit stays 1; then item_sel=0011 -> ignored.
REQ-037 Ten purchases of item 1 -> sold_out[1]=1 and an 11th valid-credit select is ignored; restock in IDLE -> sold_out[1]=0.
REQ-038 Ten during CHANGE -> coin_reject pulse and refund count unchanged; credit=62 plus ten -> coin_reject and credit stays 62.
REQ-039 Credit 5 then cancel, reset asserted on the 2nd CHANGE cycle -> next cycle IDLE, credit=0, five_out=0.
